// File: rtl/cpu_pkg.sv
// Shared encodings for the CPU run controller: FSM states,
// host control bits, halt causes and status word layout.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_HALTED = 3'd3,
    ST_SRESET = 3'd4
  } cpu_state_e;

  typedef enum logic [2:0] {
    CAUSE_NONE   = 3'd0,
    CAUSE_HALT   = 3'd1,
    CAUSE_EBREAK = 3'd2,
    CAUSE_BP     = 3'd3,
    CAUSE_STEP   = 3'd4
  } halt_cause_e;

  localparam int CTRL_W       = 5;
  localparam int CTRL_RUN     = 0;
  localparam int CTRL_STEP    = 1;
  localparam int CTRL_HALT    = 2;
  localparam int CTRL_SOFTRST = 3;
  localparam int CTRL_BP_EN   = 4;

  localparam int STS_RUNNING  = 0;
  localparam int STS_HALTED   = 1;
  localparam int STS_STATE    = 2;
  localparam int STS_CAUSE    = 5;
  localparam int STS_PCWE_REJ = 8;
  localparam int STS_RETIRE   = 9;
  localparam int RETIRE_W     = 23;

endpackage

// File: rtl/ctrl_edge_det.sv
// Registers the host control vector and flags
// per-bit rising and falling edges against it.
module ctrl_edge_det #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else     q <= d;
  end

  assign rise = d & ~q;
  assign fall = ~d & q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt controller for the core: command FSM,
// soft-reset sequencing, PC-write gating and counters.
import cpu_pkg::*;

module cpu_run_ctrl #(
  parameter int RST_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_ctrl,
  input  logic [31:0] bp_addr,
  input  logic [31:0] pc,
  input  logic        instr_retire,
  input  logic        ebreak_retire,
  input  logic        axi_pc_we,
  output logic        core_en,
  output logic        core_soft_rst,
  output logic        pc_load,
  output logic        cpu_running,
  output logic        cpu_halted,
  output logic [2:0]  cpu_state,
  output logic [31:0] cpu_status,
  output logic [31:0] cycle_count
);

  cpu_state_e          state, state_n;
  halt_cause_e         cause, cause_n;
  logic [CTRL_W-1:0]   rise, fall;
  logic                prev_run, bp_hit, halt_rise, ebrk;
  logic                pcwe_rej, clr;
  logic [7:0]          sr_cnt;
  logic [RETIRE_W-1:0] retire_cnt;
  logic                unused_ok;

  ctrl_edge_det #(.W(CTRL_W)) u_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (cpu_ctrl[CTRL_W-1:0]),
    .rise (rise),
    .fall (fall)
  );

  assign unused_ok = ^{cpu_ctrl[31:CTRL_W], fall[CTRL_W-1:1],
                       rise[CTRL_BP_EN]};

  assign halt_rise = rise[CTRL_HALT];
  assign ebrk      = instr_retire & ebreak_retire;
  // prev_run masks the first RUN cycle so resuming at a breakpoint PC proceeds
  assign bp_hit    = (state == ST_RUN) & prev_run &
                     cpu_ctrl[CTRL_BP_EN] & (pc == bp_addr);

  assign cpu_running   = (state == ST_RUN) | (state == ST_STEP);
  assign cpu_halted    = (state == ST_HALTED);
  assign core_en       = cpu_running & ~bp_hit & ~halt_rise;
  assign core_soft_rst = (state == ST_SRESET);
  assign pc_load       = axi_pc_we &
                         ((state == ST_IDLE) | (state == ST_HALTED));
  assign cpu_state     = state;

  always_comb begin
    state_n = state;
    cause_n = cause;
    if (rise[CTRL_SOFTRST]) begin
      state_n = ST_SRESET;
    end else begin
      case (state)
        ST_IDLE, ST_HALTED: begin
          if (rise[CTRL_RUN])       state_n = ST_RUN;
          else if (rise[CTRL_STEP]) state_n = ST_STEP;
        end
        ST_RUN: begin
          if (halt_rise) begin
            state_n = ST_HALTED;
            cause_n = CAUSE_HALT;
          end else if (ebrk) begin
            state_n = ST_HALTED;
            cause_n = CAUSE_EBREAK;
          end else if (bp_hit) begin
            state_n = ST_HALTED;
            cause_n = CAUSE_BP;
          end else if (fall[CTRL_RUN]) begin
            state_n = ST_IDLE;
          end
        end
        ST_STEP: begin
          if (halt_rise) begin
            state_n = ST_HALTED;
            cause_n = CAUSE_HALT;
          end else if (instr_retire) begin
            state_n = ST_HALTED;
            cause_n = ebreak_retire ? CAUSE_EBREAK : CAUSE_STEP;
          end
        end
        ST_SRESET: begin
          if (sr_cnt == 8'(RST_CYCLES - 1)) state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end
    if ((state_n == ST_RUN || state_n == ST_STEP) && state_n != state)
      cause_n = CAUSE_NONE;
    if (clr) cause_n = CAUSE_NONE;
  end

  assign clr = (state == ST_SRESET) | (state_n == ST_SRESET);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cause       <= CAUSE_NONE;
      prev_run    <= 1'b0;
      sr_cnt      <= '0;
      cycle_count <= '0;
      retire_cnt  <= '0;
      pcwe_rej    <= 1'b0;
    end else begin
      state    <= state_n;
      cause    <= cause_n;
      prev_run <= (state == ST_RUN);
      if (rise[CTRL_SOFTRST])    sr_cnt <= '0;
      else if (state == ST_SRESET) sr_cnt <= sr_cnt + 8'd1;
      if (clr) begin
        cycle_count <= '0;
        retire_cnt  <= '0;
        pcwe_rej    <= 1'b0;
      end else begin
        if (core_en) cycle_count <= cycle_count + 32'd1;
        if (core_en && instr_retire) retire_cnt <= retire_cnt + 1'b1;
        if (axi_pc_we && !pc_load) pcwe_rej <= 1'b1;
      end
    end
  end

  always_comb begin
    cpu_status = '0;
    cpu_status[STS_RUNNING]         = cpu_running;
    cpu_status[STS_HALTED]          = cpu_halted;
    cpu_status[STS_STATE +: 3]      = state;
    cpu_status[STS_CAUSE +: 3]      = cause;
    cpu_status[STS_PCWE_REJ]        = pcwe_rej;
    cpu_status[STS_RETIRE +: RETIRE_W] = retire_cnt;
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed and randomized bench for cpu_run_ctrl,
// checked against a cycle-level behavioural model.
module tb_cpu_run_ctrl;

  localparam int RSTC = 4;
  localparam int S_IDLE = 0, S_RUN = 1, S_STEP = 2;
  localparam int S_HALTED = 3, S_SRESET = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cpu_ctrl = '0;
  logic [31:0] bp_addr = 32'h10;
  logic [31:0] pc = '0;
  logic        instr_retire = 1'b0;
  logic        ebreak_retire = 1'b0;
  logic        axi_pc_we = 1'b0;
  logic        core_en, core_soft_rst, pc_load;
  logic        cpu_running, cpu_halted;
  logic [2:0]  cpu_state;
  logic [31:0] cpu_status, cycle_count;

  cpu_run_ctrl #(.RST_CYCLES(RSTC)) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_ctrl      (cpu_ctrl),
    .bp_addr       (bp_addr),
    .pc            (pc),
    .instr_retire  (instr_retire),
    .ebreak_retire (ebreak_retire),
    .axi_pc_we     (axi_pc_we),
    .core_en       (core_en),
    .core_soft_rst (core_soft_rst),
    .pc_load       (pc_load),
    .cpu_running   (cpu_running),
    .cpu_halted    (cpu_halted),
    .cpu_state     (cpu_state),
    .cpu_status    (cpu_status),
    .cycle_count   (cycle_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          m_st;
  logic [4:0]  m_prev;
  bit          m_prev_run;
  int          m_cause;
  bit          m_rej;
  int unsigned m_ret;
  logic [31:0] m_cyc;
  int          m_left;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = S_IDLE; m_prev = '0; m_prev_run = 0; m_cause = 0;
    m_rej = 0; m_ret = 0; m_cyc = '0; m_left = 0;
  endtask

  // Called at a falling edge with inputs already set; returns at the next one.
  task automatic tick();
    logic [4:0]  c, r, f;
    logic [31:0] es;
    bit bp, en, pcl, run_f;
    int ns, nc;
    #1;
    c  = cpu_ctrl[4:0];
    r  = c & ~m_prev;
    f  = ~c & m_prev;
    bp = (m_st == S_RUN) && m_prev_run && c[4] && (pc == bp_addr);
    run_f = (m_st == S_RUN) || (m_st == S_STEP);
    en = run_f && !bp && !r[2];
    pcl = axi_pc_we && (m_st == S_IDLE || m_st == S_HALTED);
    es = {m_ret[22:0], m_rej, 3'(m_cause), 3'(m_st),
          1'(m_st == S_HALTED), 1'(run_f)};
    chk("state", 32'(cpu_state), 32'(m_st));
    chk("core_en", 32'(core_en), 32'(en));
    chk("soft_rst", 32'(core_soft_rst), 32'(m_st == S_SRESET));
    chk("pc_load", 32'(pc_load), 32'(pcl));
    chk("flags", {30'd0, cpu_halted, cpu_running},
        {30'd0, 1'(m_st == S_HALTED), 1'(run_f)});
    chk("status", cpu_status, es);
    chk("cycles", cycle_count, m_cyc);
    ns = m_st; nc = m_cause;
    if (r[3]) ns = S_SRESET;
    else case (m_st)
      S_IDLE, S_HALTED: begin
        if (r[0]) ns = S_RUN;
        else if (r[1]) ns = S_STEP;
      end
      S_RUN: begin
        if (r[2]) begin ns = S_HALTED; nc = 1; end
        else if (instr_retire && ebreak_retire) begin ns = S_HALTED; nc = 2; end
        else if (bp) begin ns = S_HALTED; nc = 3; end
        else if (f[0]) ns = S_IDLE;
      end
      S_STEP: begin
        if (r[2]) begin ns = S_HALTED; nc = 1; end
        else if (instr_retire) begin ns = S_HALTED; nc = ebreak_retire ? 2 : 4; end
      end
      S_SRESET: if (m_left == 1) ns = S_IDLE;
      default: ns = S_IDLE;
    endcase
    if ((ns == S_RUN || ns == S_STEP) && ns != m_st) nc = 0;
    if (en) begin
      m_cyc = m_cyc + 32'd1;
      if (instr_retire) m_ret = (m_ret + 1) % (1 << 23);
    end
    if (axi_pc_we && !pcl) m_rej = 1;
    if (ns == S_SRESET || m_st == S_SRESET) begin
      m_cyc = '0; m_ret = 0; nc = 0; m_rej = 0;
    end
    if (r[3]) m_left = RSTC;
    else if (m_st == S_SRESET) m_left = m_left - 1;
    m_prev = c; m_prev_run = (m_st == S_RUN);
    m_st = ns; m_cause = nc;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asserts reset away from any clock edge, checks, releases at next fall.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_state", 32'(cpu_state), 32'(S_IDLE));
    chk("rst_soft", 32'(core_soft_rst), 32'd0);
    chk("rst_status", cpu_status, 32'd0);
    chk("rst_cycles", cycle_count, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  int unsigned c0, r0;

  initial begin
    model_reset();
    @(negedge clk);
    // RUN level held through reset release gives a RUN-rise
    cpu_ctrl = 32'h1;
    do_reset();
    tick();
    chk("run_entry", 32'(cpu_state), 32'(S_RUN));
    chk("run_en", 32'(core_en), 32'd1);
    chk("run_cyc0", cycle_count, 32'd0);
    tick();
    chk("run_cyc1", cycle_count, 32'd1);
    tick();
    chk("run_cyc2", cycle_count, 32'd2);
    cpu_ctrl = 32'h0;
    tick();
    chk("run_fall", 32'(cpu_state), 32'(S_IDLE));
    chk("run_cyc3", cycle_count, 32'd3);

    bp_addr = 32'h10; pc = 32'h8; cpu_ctrl = 32'h11;
    tick();
    pc = 32'hC;
    tick();
    pc = 32'h10;
    #1 chk("bp_en_low", 32'(core_en), 32'd0);
    tick();
    chk("bp_state", 32'(cpu_state), 32'(S_HALTED));
    chk("bp_cause", 32'(cpu_status[7:5]), 32'd3);
    chk("bp_halt_en", 32'(core_en), 32'd0);
    cpu_ctrl = 32'h10;
    tick();
    cpu_ctrl = 32'h11;
    tick();
    chk("resume_state", 32'(cpu_state), 32'(S_RUN));
    chk("resume_en", 32'(core_en), 32'd1);
    chk("resume_cause", 32'(cpu_status[7:5]), 32'd0);
    tick();
    pc = 32'h14;
    tick();
    chk("resume_past", 32'(cpu_state), 32'(S_RUN));

    cpu_ctrl = 32'h05;
    tick();
    chk("halt_cmd", 32'(cpu_state), 32'(S_HALTED));
    chk("halt_cause", 32'(cpu_status[7:5]), 32'd1);
    c0 = m_cyc; r0 = m_ret;
    cpu_ctrl = 32'h07;
    tick();
    chk("step_state", 32'(cpu_state), 32'(S_STEP));
    tick();
    tick();
    instr_retire = 1'b1;
    tick();
    instr_retire = 1'b0;
    chk("step_done", 32'(cpu_state), 32'(S_HALTED));
    chk("step_cause", 32'(cpu_status[7:5]), 32'd4);
    chk("step_cycles", cycle_count, c0 + 32'd3);
    chk("step_retire", 32'(cpu_status[31:9]), r0 + 32'd1);

    axi_pc_we = 1'b1;
    #1 chk("pcw_halted", 32'(pc_load), 32'd1);
    tick();
    axi_pc_we = 1'b0;
    chk("pcw_no_rej", 32'(cpu_status[8]), 32'd0);
    cpu_ctrl = 32'h06;
    tick();
    cpu_ctrl = 32'h07;
    tick();
    axi_pc_we = 1'b1;
    #1 chk("pcw_run", 32'(pc_load), 32'd0);
    tick();
    axi_pc_we = 1'b0;
    chk("pcw_rej", 32'(cpu_status[8]), 32'd1);

    force dut.cycle_count = 32'hFFFF_FFFF;
    #1 release dut.cycle_count;
    m_cyc = 32'hFFFF_FFFF;
    tick();
    chk("cyc_wrap", cycle_count, 32'd0);

    cpu_ctrl = 32'h03;
    tick();
    cpu_ctrl = 32'h0F;
    tick();
    for (int i = 0; i < RSTC; i++) begin
      chk("sr_soft", 32'(core_soft_rst), 32'd1);
      chk("sr_cyc", cycle_count, 32'd0);
      chk("sr_rej", 32'(cpu_status[8]), 32'd0);
      tick();
    end
    chk("sr_done", 32'(cpu_state), 32'(S_IDLE));
    chk("sr_done_soft", 32'(core_soft_rst), 32'd0);
    cpu_ctrl = 32'h03;
    tick();
    cpu_ctrl = 32'h0B;
    tick();
    tick();
    chk("sr_mid", 32'(core_soft_rst), 32'd1);
    do_reset();

    for (int n = 0; n < 600; n++) begin
      logic [4:0] c;
      c = cpu_ctrl[4:0];
      if ($urandom_range(7) == 0) c[0] = ~c[0];
      if ($urandom_range(7) == 0) c[1] = ~c[1];
      if ($urandom_range(9) == 0) c[2] = ~c[2];
      if ($urandom_range(59) == 0) c[3] = ~c[3];
      if ($urandom_range(9) == 0) c[4] = ~c[4];
      cpu_ctrl = {$urandom_range(1) == 1 ? 27'h5A5A5A5 : 27'h0, c};
      pc = 32'h8 + 32'($urandom_range(3)) * 32'h4;
      instr_retire = ($urandom_range(2) == 0);
      ebreak_retire = instr_retire && ($urandom_range(7) == 0);
      axi_pc_we = ($urandom_range(5) == 0);
      if (n == 300) do_reset();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 Parameter: RST_CYCLES, default 4, number of cycles core_soft_rst is held in SRESET (range 1-255).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: cpu_ctrl  input  32  host control word. Bit0 RUN, bit1 STEP, bit2 HALT, bit3 SOFTRST, bit4 BP_EN; other bits ignored.
REQ-005 Port: bp_addr  input  32  breakpoint PC.
REQ-006 Port: pc  input  32  core's current PC.
REQ-007 Port: instr_retire  input  1  one-cycle pulse when the core completes an instruction.
REQ-008 Port: ebreak_retire  input  1  qualifies instr_retire; the retired instruction was EBREAK/ECALL.
REQ-009 Port: axi_pc_we  input  1  host PC-write strobe.
REQ-010 Port: core_en  output  1  core advance enable.
REQ-011 Port: core_soft_rst  output  1  core synchronous reset request.
REQ-012 Port: pc_load  output  1  qualified PC-write strobe to the core.
REQ-013 Port: cpu_running / cpu_halted  output  1 each  state flags.
REQ-014 Port: cpu_state  output  3  state encoding.
REQ-015 Port: cpu_status  output  32  packed status word.
REQ-016 Port: cycle_count  output  32  count of core_en cycles.

Function
REQ-017 The FSM SHALL have states IDLE=0, RUN=1, STEP=2, HALTED=3, SRESET=4, driven on cpu_state.
REQ-018 Commands: RUN-rise, STEP-rise, HALT-rise, SOFTRST-rise are rising edges of cpu_ctrl bits against a registered copy; RUN-fall is the falling edge of bit0.
REQ-019 From IDLE or HALTED: RUN-rise -> RUN; STEP-rise -> STEP; otherwise the state holds.
REQ-020 From RUN: HALT-rise -> HALTED (cause 1); retire with ebreak -> HALTED (cause 2); breakpoint hit -> HALTED (cause 3); RUN-fall -> IDLE.
REQ-021 Breakpoint hit SHALL be BP_EN & pc==bp_addr & the state has been RUN for at least one full cycle, so resume from a breakpoint PC proceeds.
REQ-022 From STEP: the first instr_retire -> HALTED (cause 4, or 2 if ebreak); HALT-rise -> HALTED (cause 1).
REQ-023 SOFTRST-rise in any state -> SRESET with highest priority; the remaining priority is HALT > ebreak > breakpoint > step-complete > RUN-fall.
REQ-024 SRESET: core_soft_rst=1 for exactly RST_CYCLES cycles; cycle_count, the retire count and the halt cause clear; then -> IDLE.
REQ-025 core_en SHALL be combinational: 1 in RUN and STEP, except 0 in the cycle a breakpoint hit or HALT-rise is detected; 0 in all other states.
REQ-026 pc_load = axi_pc_we & (state IDLE or HALTED), combinational; writes in other states are dropped and the sticky status bit 8 (PCWE_REJ) is set.
REQ-027 cpu_running = (RUN or STEP); cpu_halted = HALTED.
REQ-028 cpu_status mapping:
  - [0] running, [1] halted, [4:2] state, [7:5] halt cause, [8] PCWE_REJ
  - [31:9] retire count, 23 bits, incrementing on instr_retire while core_en, wrapping modulo 2^23
REQ-029 cycle_count SHALL increment when core_en=1 and wrap modulo 2^32.
REQ-030 The halt cause holds until the next entry to RUN or STEP, which clears it to 0; PCWE_REJ clears only in SRESET or on reset.

Reset
REQ-031 When rst is asserted (asynchronous), the block SHALL go to IDLE; all registered outputs, counters, the cause, PCWE_REJ and the registered cpu_ctrl SHALL be 0.
REQ-032 A level of 1 on cpu_ctrl bit0 present at reset release SHALL produce a RUN-rise on the first clock.
REQ-033 Reset mid-SRESET SHALL abort the sequence, with core_soft_rst=0 immediately.

Structure
REQ-034 The state encoding, cpu_ctrl bit indices, cause codes and status field offsets SHALL live in a shared package cpu_pkg.
REQ-035 The edge detector SHALL be the sub-module ctrl_edge_det (registered vector, rise/fall outputs); the FSM and counters SHALL stay in cpu_run_ctrl.

Verification
REQ-036 Reset, then cpu_ctrl=0x1 -> state RUN next cycle, core_en=1, cycle_count increments each cycle; then cpu_ctrl=0x0 -> IDLE.
REQ-037 RUN with bp_addr=0x10, BP_EN set, pc reaches 0x10:
  - state HALTED and status[7:5]=3 in the same cycle core_en=0
  - toggling RUN 0->1 resumes past 0x10
REQ-038 From HALTED, STEP-rise with retire after 3 cycles -> HALTED, cause 4, retire count +1, exactly 3 core_en cycles.
REQ-039 axi_pc_we during RUN -> pc_load=0 and status[8]=1; axi_pc_we in HALTED -> pc_load=1 in the same cycle.
REQ-040 Simultaneous SOFTRST-rise and HALT-rise in RUN:
  - SRESET with core_soft_rst high for 4 cycles, counters 0, then IDLE
  - reset asserted during SRESET -> IDLE immediately
REQ-041 Preload cycle_count to 0xFFFFFFFF by forcing it, run one cycle -> 0x00000000.
